// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_if
//  Brief    : Byte-stream handshake and instruction-memory write bus for
//             the boot-time program loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    // master = the loader; slave = upstream byte source plus instruction memory
    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Brief    : Loads a header/payload/checksum byte stream into instruction
//             memory and holds the core in reset until a good image lands.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       start,
    imem_loader_if.master   bus,
    output logic            core_reset,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_HDR  = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_CSUM = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;
    localparam logic [2:0] c_ERR  = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  w_xfer;
    logic                  w_start_ok;
    logic                  w_busy_nxt;
    logic [31:0]           w_word_nxt;

    logic [7:0]            r_count;
    logic [31:0]           r_word;
    logic [7:0]            r_xor;
    logic [1:0]            r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_core_reset;

    assign w_xfer     = bus.byte_valid && r_ready;
    // Bytes enter at the top so the first byte of a word ends up in [7:0]
    assign w_word_nxt = {bus.byte_data, r_word[31:8]};

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_start_ok = start;
                if (start) w_state_nxt = c_HDR;
            end
            c_HDR: begin
                if (w_xfer) w_state_nxt = (bus.byte_data == 8'd0) ? c_CSUM : c_DATA;
            end
            c_DATA: begin
                if (w_xfer && (r_idx == 2'd3) && (r_count == 8'd1)) w_state_nxt = c_CSUM;
            end
            c_CSUM: begin
                if (w_xfer) w_state_nxt = (bus.byte_data == r_xor) ? c_DONE : c_ERR;
            end
            c_DONE, c_ERR: begin
                // A start coinciding with the done pulse is deliberately dropped
                w_start_ok = start && !r_done;
                if (w_start_ok) w_state_nxt = c_HDR;
            end
            default: w_state_nxt = c_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == c_HDR) || (w_state_nxt == c_DATA) ||
                     (w_state_nxt == c_CSUM);
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= 8'd0;
            r_word       <= 32'd0;
            r_xor        <= 8'd0;
            r_idx        <= 2'd0;
            r_addr       <= '0;
            r_imem_addr  <= '0;
            r_wdata      <= 32'd0;
            r_we         <= 1'b0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_reset <= 1'b1;
        end else begin
            r_ready <= w_busy_nxt;
            r_busy  <= w_busy_nxt;
            r_we    <= 1'b0;
            r_done  <= 1'b0;

            if (w_start_ok) begin
                r_addr       <= '0;
                r_xor        <= 8'd0;
                r_idx        <= 2'd0;
                r_core_reset <= 1'b1;
                r_err        <= 1'b0;
            end

            if (w_xfer) begin
                case (r_state)
                    c_HDR: r_count <= bus.byte_data;
                    c_DATA: begin
                        r_word <= w_word_nxt;
                        r_xor  <= r_xor ^ bus.byte_data;
                        r_idx  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_we        <= 1'b1;
                            r_wdata     <= w_word_nxt;
                            r_imem_addr <= r_addr;
                            r_addr      <= r_addr + ADDR_WIDTH'(1);
                            r_count     <= r_count - 8'd1;
                        end
                    end
                    c_CSUM: begin
                        r_done <= 1'b1;
                        if (bus.byte_data == r_xor) r_core_reset <= 1'b0;
                        else                        r_err        <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready = r_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_wdata;
    assign core_reset     = r_core_reset;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Brief    : Directed self-checking bench for the instruction-memory loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic core_reset;
    logic busy;
    logic done;
    logic err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   hdr_cyc  = 0;

    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic [7:0]  seq[$];

    imem_loader_if #(.ADDR_WIDTH(8)) bus ();

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus.master),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the byte until a transfer edge has passed; returns just after it
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = bus.byte_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_reset_values(input string pfx);
        @(negedge clk);
        check({pfx, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
        check({pfx, "_imem_we"},    {31'd0, bus.imem_we},    32'd0);
        check({pfx, "_imem_addr"},  {24'd0, bus.imem_addr},  32'd0);
        check({pfx, "_imem_wdata"}, bus.imem_wdata,          32'd0);
        check({pfx, "_core_reset"}, {31'd0, core_reset},     32'd1);
        check({pfx, "_busy"},       {31'd0, busy},           32'd0);
        check({pfx, "_done"},       {31'd0, done},           32'd0);
        check({pfx, "_err"},        {31'd0, err},            32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();
        tick();
        check_reset_values("idle");
        tick();

        // Single-word image that passes its checksum
        clear_log();
        pulse_start();
        @(negedge clk);
        check("t1_busy_in_hdr",  {31'd0, busy},           32'd1);
        check("t1_ready_in_hdr", {31'd0, bus.byte_ready}, 32'd1);
        check("t1_core_held",    {31'd0, core_reset},     32'd1);
        tick();
        seq = {8'h01, 8'h13, 8'h05, 8'h50, 8'h00, 8'h46};
        send_seq();
        @(negedge clk);
        check("t1_done",       {31'd0, done},           32'd1);
        check("t1_busy_fall",  {31'd0, busy},           32'd0);
        check("t1_ready_fall", {31'd0, bus.byte_ready}, 32'd0);
        check("t1_core_rel",   {31'd0, core_reset},     32'd0);
        check("t1_err",        {31'd0, err},            32'd0);
        tick();
        @(negedge clk);
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_nwrites", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) begin
            check("t1_addr",  {24'd0, wa_q[0]}, 32'd0);
            check("t1_wdata", wd_q[0],          32'h0050_0513);
            check("t1_we_latency", done_cyc - wc_q[0], 32'd1);
        end
        check("t1_done_count", done_cnt, 32'd1);
        tick();

        // Two words with a three-cycle valid gap mid-word; start in done cycle
        clear_log();
        pulse_start();
        @(negedge clk);
        check("t2_core_reassert", {31'd0, core_reset}, 32'd1);
        tick();
        seq = {8'h02, 8'h13, 8'h05};
        send_seq();
        repeat (3) tick();
        seq = {8'h50, 8'h00, 8'h63, 8'h00, 8'h00, 8'h00};
        foreach (seq[i]) send_byte(seq[i]);
        send_byte(8'h25);
        bus.byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("t2_done",     {31'd0, done},       32'd1);
        check("t2_core_rel", {31'd0, core_reset}, 32'd0);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t2_start_in_done_ignored", {31'd0, busy}, 32'd0);
        check("t2_nwrites", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            check("t2_addr0",  {24'd0, wa_q[0]}, 32'd0);
            check("t2_wdata0", wd_q[0],          32'h0050_0513);
            check("t2_addr1",  {24'd0, wa_q[1]}, 32'd1);
            check("t2_wdata1", wd_q[1],          32'h0000_0063);
        end
        tick();

        // Bad checksum: word still written, err raised, core held
        clear_log();
        pulse_start();
        seq = {8'h01, 8'h13, 8'h05, 8'h50, 8'h00, 8'h47};
        send_seq();
        @(negedge clk);
        check("t3_done",      {31'd0, done},       32'd1);
        check("t3_err",       {31'd0, err},        32'd1);
        check("t3_core_held", {31'd0, core_reset}, 32'd1);
        tick();
        @(negedge clk);
        check("t3_err_sticky", {31'd0, err}, 32'd1);
        check("t3_nwrites", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) check("t3_wdata", wd_q[0], 32'h0050_0513);
        tick();
        pulse_start();
        @(negedge clk);
        check("t3_err_cleared", {31'd0, err},  32'd0);
        check("t3_busy_again",  {31'd0, busy}, 32'd1);
        tick();

        // Empty image continues from the restarted load
        clear_log();
        send_byte(8'h00);
        hdr_cyc = cyc;
        send_byte(8'h00);
        bus.byte_valid = 1'b0;
        @(negedge clk);
        check("t4_done",     {31'd0, done},       32'd1);
        check("t4_core_rel", {31'd0, core_reset}, 32'd0);
        check("t4_err",      {31'd0, err},        32'd0);
        tick();
        @(negedge clk);
        check("t4_nwrites", wa_q.size(), 32'd0);
        // done asserts on the second edge after the header-accept cycle
        check("t4_done_timing", done_cyc - hdr_cyc, 32'd1);
        tick();

        // Reset after two payload bytes of a word
        clear_log();
        pulse_start();
        seq = {8'h01, 8'h13, 8'h05};
        send_seq();
        reset = 1'b1;
        tick();
        check_reset_values("t5");
        tick();
        reset = 1'b0;
        tick();
        check("t5_no_write", wa_q.size(), 32'd0);
        pulse_start();
        seq = {8'h01, 8'h13, 8'h05, 8'h50, 8'h00, 8'h46};
        send_seq();
        @(negedge clk);
        check("t5_core_rel", {31'd0, core_reset}, 32'd0);
        tick();
        @(negedge clk);
        check("t5_nwrites", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) begin
            check("t5_addr",  {24'd0, wa_q[0]}, 32'd0);
            check("t5_wdata", wd_q[0],          32'h0050_0513);
        end
        tick();

        // start pulsed during DATA has no effect
        clear_log();
        pulse_start();
        seq = {8'h02, 8'h13, 8'h05};
        send_seq();
        pulse_start();
        seq = {8'h50, 8'h00, 8'h63, 8'h00, 8'h00, 8'h00, 8'h25};
        send_seq();
        @(negedge clk);
        check("t6_done",     {31'd0, done},       32'd1);
        check("t6_err",      {31'd0, err},        32'd0);
        check("t6_core_rel", {31'd0, core_reset}, 32'd0);
        tick();
        @(negedge clk);
        check("t6_nwrites", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            check("t6_addr0",  {24'd0, wa_q[0]}, 32'd0);
            check("t6_wdata0", wd_q[0],          32'h0050_0513);
            check("t6_addr1",  {24'd0, wa_q[1]}, 32'd1);
            check("t6_wdata1", wd_q[1],          32'h0000_0063);
        end
        check("t6_done_count", done_cnt, 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory starting at word address 0. It holds the core in reset until a complete image with a correct checksum has been written, then releases it.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; must be ≥ 8.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new load; sampled only in IDLE, DONE or ERR.
- `byte_valid`  in  1  upstream byte available.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  loader can accept a byte; a transfer occurs when `byte_valid && byte_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `core_reset`  out  1  reset to the core; high while no valid image is loaded.
- `busy`  out  1  a load is in progress (HDR, DATA or CSUM).
- `done`  out  1  one-cycle pulse when a load finishes, whether it passed or failed.
- `err`  out  1  the last load had a checksum mismatch; sticky until the next `start` or `reset`.

## Operation
- Stream format: header byte N (word count, 0..255), then 4·N payload bytes, then 1 checksum byte.
- Checksum: XOR of all payload bytes. The header is excluded.
- Byte order: the first payload byte of a word goes to bits [7:0], the fourth to bits [31:24].
- States:
  - IDLE: `byte_ready`=0. Goes to HDR on `start`.
  - HDR: `byte_ready`=1. On transfer, latch N. If N=0, go to CSUM; otherwise go to DATA.
  - DATA: `byte_ready`=1. Shift bytes into a word buffer and track a 2-bit byte index. When the 4th byte is accepted, issue the word write and decrement the remaining count. When the remaining count reaches 0, go to CSUM.
  - CSUM: `byte_ready`=1. On transfer, compare the received byte with the running XOR. Go to DONE on a match, ERR on a mismatch.
  - DONE: `core_reset`=0, `err`=0.
  - ERR: `core_reset`=1, `err`=1.
- `start` in DONE or ERR:
  - Reasserts `core_reset`, clears `err`.
  - Clears the address, running XOR and byte index.
  - Goes to HDR.
- `start` in HDR, DATA or CSUM is ignored.
- Address: starts at 0 for every load and increments by 1 after each write. It wraps modulo 2^ADDR_WIDTH; no error is raised on wrap.
- A partially assembled word is never written.
- `reset` at any time, including mid-word or mid-stream:
  - Forces IDLE and discards any partial word.
  - Drives outputs to their reset values.
  - Instruction memory contents are not cleared.

## Timing
- Reset values: `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `busy`=0, `done`=0, `err`=0.
- All outputs are registered.
- Accepted throughput: one byte per cycle with no bubbles; `byte_ready` stays high for the whole HDR, DATA and CSUM phase.
- `busy` is high exactly while the state is HDR, DATA or CSUM.
- Word write latency: `imem_we` is high for exactly one cycle, in the cycle after the 4th byte of a word is accepted. `imem_addr` and `imem_wdata` are valid in that cycle.
- Gaps in `byte_valid` stall assembly without losing state; writes occur only on completed words.
- Load completion, in the cycle after the checksum byte is accepted:
  - `done` pulses for one cycle and `busy` falls.
  - `core_reset` and `err` take their final values.
- The last word's `imem_we` occurs no later than the `done` cycle.
- Back-to-back loads: `start` in the same cycle as the `done` pulse is not honoured. It must arrive in DONE or ERR, i.e. the cycle after `done` or later.

## Test plan
- Single-word pass:
  - Stimulus: `start`, then bytes 01, 13, 05, 50, 00, 46.
  - Required: one write with addr 0, wdata 0x00500513; `done` pulse; `core_reset` 1→0; `err`=0.
- Two words with valid gaps:
  - Stimulus: N=2, words 0x00500513 and 0x00000063, checksum 0x25, with `byte_valid` low for 3 cycles mid-word.
  - Required: writes to addr 0 and addr 1 with correct data; no extra `imem_we` during the gaps.
- Bad checksum:
  - Stimulus: the single-word stream with a checksum byte of 0x47.
  - Required: write still occurs; `done` pulses; `err`=1; `core_reset` stays 1.
  - Then `start` clears `err` on the following cycle.
- Empty image:
  - Stimulus: N=0, checksum 0x00.
  - Required: no `imem_we`; `done` pulse 2 cycles after the header is accepted; `core_reset`=0.
- Reset mid-load:
  - Stimulus: `reset` after 2 payload bytes of a word.
  - Required: state returns to IDLE with no write; all outputs at reset values.
  - A fresh `start` with a full stream writes starting at addr 0.
- Start while busy:
  - Stimulus: pulse `start` during DATA.
  - Required: no effect; the address sequence and checksum are unaffected.
